dbg_trace_capture: RTL

Parametrised debug snapshot unit for the pipelined CPU top. On each capture pulse it samples CHANNELS probe words of WIDTH bits (PC, instruction, writeback data, HI/LO, ...) into a DEPTH-entry snapshot FIFO. It then streams each snapshot as a framed, checksummed byte sequence over a valid/ready byte interface to the UART transmitter. It generalises the fixed-format debug packager to arbitrary channel count and width, and adds buffering, sequence numbering and overflow detection.

---
 rtl/dbg_trace_capture.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dbg_trace_capture.sv
// rtl/dbg_trace_capture.sv - debug snapshot FIFO with framed, checksummed byte streaming
// Captures CHANNELS x WIDTH probe words plus a sequence number; emits SYNC, SEQH, SEQL, data, CHK.
module dbg_trace_capture #(
  parameter int          CHANNELS  = 8,
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      capture,
  input  logic                      arm,
  input  logic                      clear_ovf,
  input  logic [CHANNELS*WIDTH-1:0] probe_i,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      overflow,
  output logic [15:0]               frame_count,
  output logic                      busy
);

  localparam int DW     = CHANNELS * WIDTH;
  localparam int EW     = DW + 16;
  localparam int NBYTES = DW / 8;
  localparam int BPW    = WIDTH / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(NBYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_SEQH, S_SEQL, S_DATA, S_CHK
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    data_d;
  logic          valid_d;

  logic          accept, pop, armed_cap, full, wr_en, drop;
  logic [EW-1:0] head;
  logic [15:0]   head_seq;
  logic [DW-1:0] head_data;

  assign accept    = tx_valid && tx_ready;
  assign pop       = accept && (state_q == S_CHK);
  assign armed_cap = capture && arm;
  assign full      = (count_q == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot the write needs.
  assign wr_en     = armed_cap && (!full || pop);
  assign drop      = armed_cap && full && !pop;
  assign head      = mem[rd_ptr];
  assign head_seq  = head[EW-1 -: 16];
  assign head_data = head[DW-1:0];

  // Byte k of the payload: channel k/BPW, most significant byte of each word first.
  function automatic logic [7:0] pick(input logic [DW-1:0] d, input logic [CW-1:0] k);
    int ki, ch, j;
    ki = int'(k);
    ch = ki / BPW;
    j  = ki % BPW;
    return d[ch*WIDTH + (BPW-1-j)*8 +: 8];
  endfunction

  always_comb begin
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = tx_data;
    valid_d = tx_valid;
    idx_d   = idx_q;
    chk_d   = chk_q;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        state_d = S_SYNC;
        valid_d = 1'b1;
        data_d  = SYNC_BYTE;
      end
      S_SYNC: if (accept) begin
        state_d = S_SEQH;
        data_d  = head_seq[15:8];
        chk_d   = 8'h00;
      end
      S_SEQH: if (accept) begin
        state_d = S_SEQL;
        data_d  = head_seq[7:0];
        chk_d   = chk_q ^ tx_data;
      end
      S_SEQL: if (accept) begin
        state_d = S_DATA;
        idx_d   = '0;
        data_d  = pick(head_data, '0);
        chk_d   = chk_q ^ tx_data;
      end
      S_DATA: if (accept) begin
        chk_d = chk_q ^ tx_data;
        if (idx_q == CW'(NBYTES-1)) begin
          state_d = S_CHK;
          data_d  = chk_q ^ tx_data;
        end else begin
          idx_d  = idx_q + 1'b1;
          data_d = pick(head_data, idx_q + 1'b1);
        end
      end
      S_CHK: if (accept) begin
        if (count_d != '0) begin
          state_d = S_SYNC;
          data_d  = SYNC_BYTE;
        end else begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          data_d  = 8'h00;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      idx_q       <= '0;
      chk_q       <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow    <= 1'b0;
      frame_count <= 16'h0000;
      busy        <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_data  <= data_d;
      tx_valid <= valid_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      count_q  <= count_d;
      busy     <= (state_d != S_IDLE) || (count_d != '0);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (armed_cap) frame_count <= frame_count + 16'h0001;
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {frame_count, probe_i};
  end

endmodule
